tff_updown_counter: RTL and testbench



---
 rtl/tff_updown_counter_if.sv | 23 ++
 rtl/tff_updown_counter.sv | 81 ++++++++
 tb/tb_tff_updown_counter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/tff_updown_counter_if.sv
// Control/status bundle for tff_updown_counter: count controls in, counter state and flags out.
interface tff_updown_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
  logic             tc;
  logic             wrap;

  modport master (
    output en, up, load, din,
    input  q, qbar, tc, wrap
  );

  modport slave (
    input  en, up, load, din,
    output q, qbar, tc, wrap
  );
endinterface

// File: rtl/tff_updown_counter.sv
// Up/down modulo counter built from per-bit toggle flip-flops with load, tc and wrap pulse.
// Define TFF_UPDOWN_SATURATE_EN to saturate at the limits instead of wrapping.
module tff_updown_counter #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 16
) (
  input logic                clk,
  input logic                reset,
  tff_updown_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);

  if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
    $error("tff_updown_counter: WIDTH must be in 1..16");
  end
  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $error("tff_updown_counter: MODULUS must be in 2..2**WIDTH");
  end

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] t, t_up, t_dn;
  logic [WIDTH-1:0] target, load_val;
  logic             wrap_q, wrap_d;
  logic             limit;

  // Toggle enables: bit i toggles when all lower bits are 1 (up) or all 0 (down).
  always_comb begin
    logic acc_up, acc_dn;
    acc_up = 1'b1;
    acc_dn = 1'b1;
    t_up   = '0;
    t_dn   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      t_up[i] = acc_up;
      t_dn[i] = acc_dn;
      acc_up  = acc_up & q_q[i];
      acc_dn  = acc_dn & ~q_q[i];
    end
  end

  always_comb begin
    limit    = bus.up ? (q_q == MaxVal) : (q_q == '0);
    target   = bus.up ? '0 : MaxVal;
    load_val = (bus.din > MaxVal) ? MaxVal : bus.din;
    t        = '0;
    wrap_d   = 1'b0;
    if (bus.load) begin
      t = q_q ^ load_val;
    end else if (bus.en) begin
      if (limit) begin
`ifdef TFF_UPDOWN_SATURATE_EN
        t = '0;
`else
        // Wrap still goes through the toggle bank: toggle exactly the differing bits.
        t      = q_q ^ target;
        wrap_d = 1'b1;
`endif
      end else begin
        t = bus.up ? t_up : t_dn;
      end
    end
    q_d = q_q ^ t;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.q    = q_q;
  assign bus.qbar = ~q_q;
  assign bus.tc   = limit;
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_tff_updown_counter.sv
// Randomized and directed bench for tff_updown_counter against an arithmetic reference model.
// Three instances (4/10, 3/8, 2/2) share the same stimulus.
module tb_tff_updown_counter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  tff_updown_counter_if #(.WIDTH(4)) bus_a ();
  tff_updown_counter_if #(.WIDTH(3)) bus_b ();
  tff_updown_counter_if #(.WIDTH(2)) bus_c ();

  tff_updown_counter #(.WIDTH(4), .MODULUS(10)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  tff_updown_counter #(.WIDTH(3), .MODULUS(8))  dut_b (.clk(clk), .reset(reset), .bus(bus_b));
  tff_updown_counter #(.WIDTH(2), .MODULUS(2))  dut_c (.clk(clk), .reset(reset), .bus(bus_c));

  int n_checks = 0;
  int n_fail   = 0;

  int mods[3]   = '{10, 8, 2};
  int widths[3] = '{4, 3, 2};
  int mq[3];
  int mw[3];
  bit started = 1'b0;
  int wrap_seen = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int obs_q(input int i);
    case (i)
      0:       return int'(bus_a.q);
      1:       return int'(bus_b.q);
      default: return int'(bus_c.q);
    endcase
  endfunction

  function automatic int obs_qbar(input int i);
    case (i)
      0:       return int'(bus_a.qbar);
      1:       return int'(bus_b.qbar);
      default: return int'(bus_c.qbar);
    endcase
  endfunction

  function automatic int obs_tc(input int i);
    case (i)
      0:       return int'(bus_a.tc);
      1:       return int'(bus_b.tc);
      default: return int'(bus_c.tc);
    endcase
  endfunction

  function automatic int obs_wrap(input int i);
    case (i)
      0:       return int'(bus_a.wrap);
      1:       return int'(bus_b.wrap);
      default: return int'(bus_c.wrap);
    endcase
  endfunction

  function automatic int exp_tc(input int i, input bit up);
    return up ? int'(mq[i] == mods[i] - 1) : int'(mq[i] == 0);
  endfunction

  // One clock: drive inputs, check tc combinationally, clock, advance model, check outputs.
  task automatic step(input bit rst, input bit ld, input bit en, input bit up, input int din);
    string nm;
    reset      = rst;
    bus_a.load = ld;  bus_b.load = ld;  bus_c.load = ld;
    bus_a.en   = en;  bus_b.en   = en;  bus_c.en   = en;
    bus_a.up   = up;  bus_b.up   = up;  bus_c.up   = up;
    bus_a.din  = 4'(din);
    bus_b.din  = 3'(din);
    bus_c.din  = 2'(din);
    #1;
    if (started) begin
      for (int i = 0; i < 3; i++) begin
        nm = $sformatf("tc_pre[%0d]", i);
        check(nm, obs_tc(i), exp_tc(i, up));
      end
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      int m, d;
      bit at_lim;
      m      = mods[i];
      d      = din % (1 << widths[i]);
      at_lim = up ? (mq[i] == m - 1) : (mq[i] == 0);
      mw[i]  = 0;
      if (rst) begin
        mq[i] = 0;
      end else if (ld) begin
        mq[i] = (d > m - 1) ? m - 1 : d;
      end else if (en) begin
        if (at_lim) begin
`ifndef TFF_UPDOWN_SATURATE_EN
          mq[i] = up ? 0 : m - 1;
          mw[i] = 1;
`endif
        end else begin
          mq[i] = up ? mq[i] + 1 : mq[i] - 1;
        end
      end
    end
    if (rst) started = 1'b1;
    #1;
    if (started) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("q[%0d]", i), obs_q(i), mq[i]);
        check($sformatf("qbar[%0d]", i), obs_qbar(i), (~mq[i]) & ((1 << widths[i]) - 1));
        check($sformatf("wrap[%0d]", i), obs_wrap(i), mw[i]);
        check($sformatf("tc[%0d]", i), obs_tc(i), exp_tc(i, up));
        wrap_seen += mw[i];
      end
    end
  endtask

  initial begin
    bus_a.en = 0; bus_a.up = 1; bus_a.load = 0; bus_a.din = '0;
    bus_b.en = 0; bus_b.up = 1; bus_b.load = 0; bus_b.din = '0;
    bus_c.en = 0; bus_c.up = 1; bus_c.load = 0; bus_c.din = '0;
    for (int i = 0; i < 3; i++) begin
      mq[i] = 0;
      mw[i] = 0;
    end
    @(posedge clk);
    #1;

    // Reset, then count up 12 cycles through the 9->0 wrap.
    step(1, 0, 0, 1, 0);
    for (int k = 0; k < 12; k++) step(0, 0, 1, 1, 0);
`ifndef TFF_UPDOWN_SATURATE_EN
    check("up12_final_q", int'(bus_a.q), 2);
`endif
    // Load 3, count down 5 through 0->9.
    step(0, 1, 0, 0, 3);
    for (int k = 0; k < 5; k++) step(0, 0, 1, 0, 0);
    // Clamped load, then load beats en.
    step(0, 1, 0, 1, 13);
    check("clamp_q", int'(bus_a.q), 9);
    step(0, 1, 1, 1, 5);
    // Count to 6 then reset beats load and en; hold for 3.
    step(0, 0, 1, 1, 0);
    step(1, 1, 1, 1, 4);
    check("reset_q", int'(bus_a.q), 0);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 1, 0);
    // Alternate direction every cycle from 5.
    step(0, 1, 0, 1, 5);
    for (int k = 0; k < 4; k++) step(0, 0, 1, k % 2 == 0, 0);
    // Load 8 and push into the upper limit.
    step(0, 1, 0, 1, 8);
    for (int k = 0; k < 3; k++) step(0, 0, 1, 1, 0);

    // Randomized phase.
    for (int k = 0; k < 600; k++) begin
      step($urandom_range(0, 31) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
           1'($urandom_range(0, 1)), $urandom_range(0, 15));
    end

`ifndef TFF_UPDOWN_SATURATE_EN
    check("wrap_seen_nonzero", int'(wrap_seen > 0), 1);
`else
    check("wrap_seen_zero", wrap_seen, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
